dffram_arbiter: RTL and testbench

Two-port round-robin arbiter sharing one single-port DFFRAM macro (EN, WE[3:0], Di[31:0], Do[31:0], byte address A, one-cycle registered read) between two 32-bit requesters (e.g. instruction fetch on port 0, data load/store on port 1). It accepts at most one access per cycle, drives the RAM, and returns each result to the requester that issued it. The arbiter sits between the bus masters and the RAM macro. It adds no wait states beyond the RAM's own one-cycle read latency.

---
 rtl/dffram_arbiter.sv | 125 ++++++++++++
 tb/tb_dffram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port DFFRAM macro.
// One access per cycle; each response returns to its issuer one cycle later.
module dffram_arbiter #(
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 p0_valid_i,
    output logic                 p0_ready_o,
    input  logic [3:0]           p0_we_i,
    input  logic [AddrWidth-1:0] p0_addr_i,
    input  logic [31:0]          p0_wdata_i,
    output logic                 p0_rsp_valid_o,
    output logic [31:0]          p0_rsp_rdata_o,

    input  logic                 p1_valid_i,
    output logic                 p1_ready_o,
    input  logic [3:0]           p1_we_i,
    input  logic [AddrWidth-1:0] p1_addr_i,
    input  logic [31:0]          p1_wdata_i,
    output logic                 p1_rsp_valid_o,
    output logic [31:0]          p1_rsp_rdata_o,

    output logic                 ram_en_o,
    output logic [3:0]           ram_we_o,
    output logic [AddrWidth-1:0] ram_a_o,
    output logic [31:0]          ram_di_o,
    input  logic [31:0]          ram_do_i
);

    logic        prio_q, prio_d;
    logic        pend_v_q, pend_v_d;
    logic        pend_port_q, pend_port_d;
    logic [31:0] hold0_q, hold0_d;
    logic [31:0] hold1_q, hold1_d;

    logic gnt0, gnt1, gnt_any;
    logic rsp0, rsp1;

    // Grants are masked while reset is held so nothing reaches the RAM.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni) begin
            if (p0_valid_i && p1_valid_i) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = p0_valid_i;
                gnt1 = p1_valid_i;
            end
        end
        gnt_any = gnt0 | gnt1;
    end

    assign p0_ready_o = gnt0;
    assign p1_ready_o = gnt1;

    always_comb begin
        ram_en_o = gnt_any;
        ram_we_o = 4'b0000;
        ram_a_o  = '0;
        ram_di_o = 32'h0;
        if (gnt0) begin
            ram_we_o = p0_we_i;
            ram_a_o  = p0_addr_i;
            ram_di_o = p0_wdata_i;
        end else if (gnt1) begin
            ram_we_o = p1_we_i;
            ram_a_o  = p1_addr_i;
            ram_di_o = p1_wdata_i;
        end
    end

    assign rsp0 = pend_v_q & ~pend_port_q;
    assign rsp1 = pend_v_q & pend_port_q;

    assign p0_rsp_valid_o = rsp0;
    assign p1_rsp_valid_o = rsp1;
    assign p0_rsp_rdata_o = rsp0 ? ram_do_i : hold0_q;
    assign p1_rsp_rdata_o = rsp1 ? ram_do_i : hold1_q;

    always_comb begin
        prio_d      = prio_q;
        pend_v_d    = gnt_any;
        pend_port_d = pend_port_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        if (gnt_any) begin
            prio_d      = ~gnt1;
            pend_port_d = gnt1;
        end
        if (rsp0) begin
            hold0_d = ram_do_i;
        end
        if (rsp1) begin
            hold1_d = ram_do_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_port_q <= 1'b0;
            hold0_q     <= 32'h0;
            hold1_q     <= 32'h0;
        end else begin
            prio_q      <= prio_d;
            pend_v_q    <= pend_v_d;
            pend_port_q <= pend_port_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(gnt0 && gnt1));
    a_rsp_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp0 && rsp1));
`endif

endmodule

// File: tb/tb_dffram_arbiter.sv
// Randomised bench for dffram_arbiter: a RAM macro model, a transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_dffram_arbiter;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_valid, p1_valid;
    logic [3:0]    p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_ready, p1_ready;
    logic          p0_rsp_valid, p1_rsp_valid;
    logic [31:0]   p0_rsp_rdata, p1_rsp_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dffram_arbiter #(.AddrWidth(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .p0_valid_i     (p0_valid),
        .p0_ready_o     (p0_ready),
        .p0_we_i        (p0_we),
        .p0_addr_i      (p0_addr),
        .p0_wdata_i     (p0_wdata),
        .p0_rsp_valid_o (p0_rsp_valid),
        .p0_rsp_rdata_o (p0_rsp_rdata),
        .p1_valid_i     (p1_valid),
        .p1_ready_o     (p1_ready),
        .p1_we_i        (p1_we),
        .p1_addr_i      (p1_addr),
        .p1_wdata_i     (p1_wdata),
        .p1_rsp_valid_o (p1_rsp_valid),
        .p1_rsp_rdata_o (p1_rsp_rdata),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_a_o        (ram_a),
        .ram_di_o       (ram_di),
        .ram_do_i       (ram_do)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // RAM macro: registered read of the old word, byte writes, word index A/4.
    logic [31:0] ram_mem [64] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ram_en) begin
            ram_do <= ram_mem[ram_a[7:2]];
            ram_mem[ram_a[7:2]] <= merge(ram_mem[ram_a[7:2]], ram_di, ram_we);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: favoured port, the one outstanding response, per-port held data.
    int          m_fav;
    bit          m_pend;
    int          m_pport;
    logic [31:0] m_pdata;
    logic [31:0] m_hold [2];
    logic [31:0] m_mem [64] = '{default: 32'h0};
    int          m_g;
    logic [3:0]  m_we;
    logic [7:0]  m_a;
    logic [31:0] m_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_ready0", p0_ready, 1'b0);
            chk1("rst_ready1", p1_ready, 1'b0);
            chk1("rst_ram_en", ram_en, 1'b0);
            chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
            chk1("rst_rspv0", p0_rsp_valid, 1'b0);
            chk1("rst_rspv1", p1_rsp_valid, 1'b0);
            chk("rst_rdata0", p0_rsp_rdata, 32'h0);
            chk("rst_rdata1", p1_rsp_rdata, 32'h0);
            m_fav = 0; m_pend = 0; m_pport = 0; m_hold[0] = 0; m_hold[1] = 0;
        end else begin
            if (p0_valid && p1_valid) m_g = m_fav;
            else if (p0_valid)        m_g = 0;
            else if (p1_valid)        m_g = 1;
            else                      m_g = -1;
            m_we = 4'h0; m_a = 8'h0; m_d = 32'h0;
            if (m_g == 0) begin m_we = p0_we; m_a = p0_addr; m_d = p0_wdata; end
            if (m_g == 1) begin m_we = p1_we; m_a = p1_addr; m_d = p1_wdata; end
            chk1("ready0", p0_ready, m_g == 0);
            chk1("ready1", p1_ready, m_g == 1);
            chk1("ram_en", ram_en, m_g >= 0);
            chk("ram_we", {28'h0, ram_we}, {28'h0, m_we});
            chk("ram_a", {24'h0, ram_a}, {24'h0, m_a});
            chk("ram_di", ram_di, m_d);
            chk1("rspv0", p0_rsp_valid, m_pend && m_pport == 0);
            chk1("rspv1", p1_rsp_valid, m_pend && m_pport == 1);
            chk1("rsp_exclusive", p0_rsp_valid && p1_rsp_valid, 1'b0);
            chk("rdata0", p0_rsp_rdata, (m_pend && m_pport == 0) ? m_pdata : m_hold[0]);
            chk("rdata1", p1_rsp_rdata, (m_pend && m_pport == 1) ? m_pdata : m_hold[1]);
            if (m_pend) m_hold[m_pport] = m_pdata;
            m_pend = (m_g >= 0);
            if (m_g >= 0) begin
                m_pport = m_g;
                m_pdata = m_mem[m_a[7:2]];
                m_mem[m_a[7:2]] = merge(m_mem[m_a[7:2]], m_d, m_we);
                m_fav = 1 - m_g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    task automatic drive(input int p, input logic [3:0] we, input logic [7:0] a,
                         input logic [31:0] d);
        if (p == 0) begin
            p0_valid = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    // Single-port access: accepted in the same cycle, response one cycle later.
    task automatic xfer(input string name, input int p, input logic [3:0] we,
                        input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
        tick();
        idle();
        drive(p, we, a, d);
        #2;
        chk1({name, "_ready"}, (p == 0) ? p0_ready : p1_ready, 1'b1);
        tick();
        idle();
        #2;
        chk1({name, "_rspv"}, (p == 0) ? p0_rsp_valid : p1_rsp_valid, 1'b1);
        chk({name, "_rdata"}, (p == 0) ? p0_rsp_rdata : p1_rsp_rdata, exp_rd);
    endtask

    bit acc0, acc1;

    initial begin
        rst_n = 1'b0;
        p0_valid = 1'b1; p0_we = 4'h0; p0_addr = 8'h00; p0_wdata = 32'h0;
        p1_valid = 1'b1; p1_we = 4'h0; p1_addr = 8'h04; p1_wdata = 32'h0;
        #3;
        chk1("reset_ready0", p0_ready, 1'b0);
        chk1("reset_ready1", p1_ready, 1'b0);
        chk1("reset_ram_en", ram_en, 1'b0);
        chk1("reset_rspv1", p1_rsp_valid, 1'b0);
        chk("reset_rdata0", p0_rsp_rdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        chk1("first_grant_p0", p0_ready, 1'b1);
        chk1("first_grant_not_p1", p1_ready, 1'b0);
        tick();
        idle();
        tick();

        xfer("wr10", 0, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0);
        xfer("rd10", 0, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF);
        tick();
        #2;
        chk("hold0_after_rd", p0_rsp_rdata, 32'hDEADBEEF);

        xfer("wr20", 1, 4'hF, 8'h20, 32'h11223344, 32'h0);
        xfer("bwr20", 1, 4'b0010, 8'h20, 32'h0000AA00, 32'h11223344);
        xfer("rd20", 1, 4'h0, 8'h20, 32'h0, 32'h1122AA44);

        // Contention straight after reset: strict alternation starting at port 0.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 4'h0, 8'h10, 32'h0);
            drive(1, 4'h0, 8'h20, 32'h0);
            #2;
            chk1("contend_gnt0", p0_ready, (i % 2) == 0);
            chk1("contend_gnt1", p1_ready, (i % 2) == 1);
            chk1("contend_rspv0", p0_rsp_valid, i > 0 && (i % 2) == 1);
            chk1("contend_rspv1", p1_rsp_valid, i > 0 && (i % 2) == 0);
            tick();
        end
        idle();
        #2;
        chk1("contend_last_rspv1", p1_rsp_valid, 1'b1);
        chk("contend_last_rdata1", p1_rsp_rdata, 32'h1122AA44);

        // Pointer retention through idle cycles.
        tick();
        drive(1, 4'h0, 8'h04, 32'h0);
        #2;
        chk1("retain_p1_alone", p1_ready, 1'b1);
        tick();
        idle();
        tick();
        tick();
        tick();
        drive(0, 4'h0, 8'h00, 32'h0);
        drive(1, 4'h0, 8'h04, 32'h0);
        #2;
        chk1("retain_p0_first", p0_ready, 1'b1);
        chk1("retain_p1_waits", p1_ready, 1'b0);
        tick();
        idle();
        tick();

        // Mid-flight reset discards the pending p1 response and clears its hold.
        xfer("p1rd10", 1, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF);
        tick();
        drive(1, 4'h0, 8'h20, 32'h0);
        #2;
        chk1("midrst_accept", p1_ready, 1'b1);
        tick();
        rst_n = 1'b0;
        idle();
        #2;
        chk1("midrst_no_rspv", p1_rsp_valid, 1'b0);
        chk("midrst_hold1", p1_rsp_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(0, 4'h0, 8'h00, 32'h0);
        drive(1, 4'h0, 8'h04, 32'h0);
        #2;
        chk1("midrst_no_rspv_after", p1_rsp_valid, 1'b0);
        chk1("midrst_prio_p0", p0_ready, 1'b1);
        tick();
        idle();

        // Randomised traffic with valid-hold handshakes and occasional resets.
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            if (!p0_valid || acc0) begin
                p0_valid = ($urandom_range(0, 99) < 65);
                p0_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                p0_addr  = 8'($urandom_range(0, 31));
                p0_wdata = $urandom;
            end
            if (!p1_valid || acc1) begin
                p1_valid = ($urandom_range(0, 99) < 65);
                p1_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                p1_addr  = 8'($urandom_range(0, 31));
                p1_wdata = $urandom;
            end
            #2;
            acc0 = p0_valid && p0_ready;
            acc1 = p1_valid && p1_ready;
        end
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
